ram_arb_mp: RTL and testbench

- Parametrised multi-port successor to the team's single-port chip-select RAM.
- N request ports share one synchronous memory array through a round-robin arbiter with valid/ready handshakes, per-byte write enables and a configurable registered read latency.
- Replaces the tri-state shared data bus with separate write-data and read-data paths.
- Sits between the CPU datapath/DMA masters and on-chip data memory.

---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/ram_arb_mp.sv | 120 ++++++++++++
 tb/tb_ram_arb_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared width helpers for the multi-port RAM arbiter.
package ram_arb_pkg;
  localparam int BYTE_W = 8;
  function automatic int be_width(input int data_width);
    return data_width / BYTE_W;
  endfunction
  function automatic int id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a pointer that moves past each winner.
module rr_arbiter import ram_arb_pkg::*; #(
  parameter int N = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic [id_width(N)-1:0]  gnt_idx,
  output logic                    gnt_any
);
  localparam int IW = id_width(N);
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  // grants are held off while reset is asserted so ready is 0 during reset
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!gnt_any && rst_n && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
        gnt[idx] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (gnt_any) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/ram_arb_mp.sv
// ram_arb_mp: N-port round-robin arbitrated synchronous RAM with byte enables and 1/2-cycle read latency.
// Define RAM_ARB_ERR_EN to add the rsp_err out-of-range indication port.
module ram_arb_mp import ram_arb_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 1 << ADDR_WIDTH,
  parameter int NUM_PORTS  = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_PORTS-1:0]                         req_valid,
  output logic [NUM_PORTS-1:0]                         req_ready,
  input  logic [NUM_PORTS-1:0]                         req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]              req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]              req_wdata,
  input  logic [NUM_PORTS*be_width(DATA_WIDTH)-1:0]    req_be,
`ifdef RAM_ARB_ERR_EN
  output logic [NUM_PORTS-1:0]                         rsp_err,
`endif
  output logic [NUM_PORTS-1:0]                         rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]              rsp_rdata
);
  localparam int BW = be_width(DATA_WIDTH);
  localparam int IW = id_width(NUM_PORTS);
  typedef struct packed {
    logic                  valid;
    logic [IW-1:0]         port_id;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rd_stage_t;
  logic [NUM_PORTS-1:0]           gnt;
  logic [IW-1:0]                  gidx;
  logic                           acc;
  logic                           we;
  logic                           in_range;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [DATA_WIDTH-1:0]          wdata;
  logic [BW-1:0]                  be;
  logic [DATA_WIDTH-1:0]          mem [LENGTH];
  rd_stage_t                      s1;
  rd_stage_t                      so;
  logic                           werr;
  logic [IW-1:0]                  werr_id;
  logic [NUM_PORTS*DATA_WIDTH-1:0] hold;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .gnt_any (acc)
  );

  assign req_ready = gnt;
  assign we        = req_we[gidx];
  assign addr      = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata     = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign be        = req_be[gidx*BW +: BW];
  assign in_range  = int'(addr) < LENGTH;

  always_ff @(posedge clk)
    if (acc && we && in_range)
      for (int b = 0; b < BW; b++)
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1      <= '0;
      werr    <= 1'b0;
      werr_id <= '0;
    end else begin
      s1.valid <= acc && !we;
      s1.err   <= acc && !we && !in_range;
      werr     <= acc && we && !in_range;
      werr_id  <= gidx;
      if (acc && !we) begin
        s1.port_id <= gidx;
        s1.data    <= in_range ? mem[addr] : '0;
      end
    end

  generate
    if (OUT_REG != 0) begin : g_oreg
      rd_stage_t s2;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s2 <= '0;
        else s2 <= s1;
      assign so = s2;
    end else begin : g_noreg
      assign so = s1;
    end
  endgenerate

  // unaddressed ports keep showing their last read data
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = hold;
    if (so.valid) begin
      rsp_valid[so.port_id] = 1'b1;
      rsp_rdata[so.port_id*DATA_WIDTH +: DATA_WIDTH] = so.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else hold <= rsp_rdata;

`ifdef RAM_ARB_ERR_EN
  always_comb begin
    rsp_err = '0;
    if (so.valid && so.err) rsp_err[so.port_id] = 1'b1;
    if (werr) rsp_err[werr_id] = 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = ^{so.err, werr, werr_id};
`endif
endmodule

// File: tb/tb_ram_arb_mp.sv
// tb_ram_arb_mp: scoreboard bench for a 3-port LENGTH=3000 instance and a 1-port OUT_REG=1 instance.
module tb_ram_arb_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  v = '0, we = '0;
  logic [35:0] addr = '0;
  logic [95:0] wdata = '0;
  logic [11:0] be = '0;
  logic [2:0]  rdy, rv;
  logic [95:0] rd;
  logic        b_v = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_rdy, b_rv;
  logic [31:0] b_rd;
`ifdef RAM_ARB_ERR_EN
  logic [2:0]  err;
  logic        b_err;
`endif

  ram_arb_mp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LENGTH(3000), .NUM_PORTS(3), .OUT_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(rdy), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_be(be),
`ifdef RAM_ARB_ERR_EN
    .rsp_err(err),
`endif
    .rsp_valid(rv), .rsp_rdata(rd));

  ram_arb_mp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_PORTS(1), .OUT_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_v), .req_ready(b_rdy), .req_we(b_we), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_be(b_be),
`ifdef RAM_ARB_ERR_EN
    .rsp_err(b_err),
`endif
    .rsp_valid(b_rv), .rsp_rdata(b_rd));

  typedef struct {int port; logic [31:0] data; int due; logic err;} exp_t;
  typedef struct {int port; int due;} werr_t;
  typedef struct {logic [2:0] v; logic [2:0] rdy;} vec_t;
  exp_t        sb[$];
  werr_t       wq[$];
  logic [31:0] model [0:2999];
  int          nacc [3];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;
  vec_t        tv [13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: accepted reads are queued with model data and due cycle, checked when due
  always @(negedge clk) begin : mon
    exp_t e;
    logic [2:0] experr;
    int a;
    if (rst_n) begin
      experr = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", 128'(rv), 128'(3'b001 << e.port));
        chk("rsp_rdata", 128'(rd[e.port*32 +: 32]), 128'(e.data));
        experr[e.port] = e.err;
      end else chk("rsp_idle", 128'(rv), 128'(0));
`ifdef RAM_ARB_ERR_EN
      if (wq.size() > 0 && wq[0].due == cyc) begin
        experr[wq[0].port] = 1'b1;
        void'(wq.pop_front());
      end
      chk("rsp_err", 128'(err), 128'(experr));
`endif
      for (int p = 0; p < 3; p++)
        if (v[p] && rdy[p]) begin
          a = int'(addr[p*12 +: 12]);
          nacc[p]++;
          if (we[p]) begin
            if (a < 3000) begin
              for (int b = 0; b < 4; b++)
                if (be[p*4+b]) model[a][b*8 +: 8] = wdata[p*32+b*8 +: 8];
            end else wq.push_back('{p, cyc + 1});
          end else sb.push_back('{p, (a < 3000) ? model[a] : 32'h0, cyc + 1, a >= 3000});
        end
    end
  end

  task automatic a_op(input int p, input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    v[p] = 1'b1; we[p] = w; addr[p*12 +: 12] = a; wdata[p*32 +: 32] = d; be[p*4 +: 4] = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rdy[p];
    end
    chk("a_grant_wait", 128'(ok), 128'(1));
    @(posedge clk); #1;
    v[p] = 1'b0;
  endtask

  task automatic b_op(input logic w, input logic [11:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    b_v = 1'b1; b_we = w; b_addr = a; b_wdata = d; b_be = 4'hF;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = b_rdy;
    end
    chk("b_grant_wait", 128'(ok), 128'(1));
    @(posedge clk); #1;
    b_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv = '{'{3'b111, 3'b001}, '{3'b111, 3'b010}, '{3'b111, 3'b100}, '{3'b111, 3'b001},
           '{3'b111, 3'b010}, '{3'b111, 3'b100}, '{3'b110, 3'b010}, '{3'b101, 3'b100},
           '{3'b001, 3'b001}, '{3'b000, 3'b000}, '{3'b010, 3'b010}, '{3'b011, 3'b001},
           '{3'b010, 3'b010}};
    v = 3'b111; b_v = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(rdy), 128'(0));
    chk("rst_valid", 128'(rv), 128'(0));
    chk("rst_rdata", 128'(rd), 128'(0));
    chk("rst_b_ready", 128'(b_rdy), 128'(0));
    chk("rst_b_valid", 128'(b_rv), 128'(0));
    chk("rst_b_rdata", 128'(b_rd), 128'(0));
    @(posedge clk); #1;
    v = '0; b_v = 1'b0; rst_n = 1'b1;

    a_op(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    a_op(0, 1'b0, 12'h010, 32'h0, 4'h0);
    @(negedge clk);
    chk("a_read_deadbeef", 128'(rd[31:0]), 128'(32'hDEADBEEF));
    a_op(0, 1'b1, 12'd5, 32'hFFFFFFFF, 4'hF);
    a_op(0, 1'b1, 12'd5, 32'h00000000, 4'h5);
    a_op(0, 1'b0, 12'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk("a_byte_en", 128'(rd[31:0]), 128'(32'hFF00FF00));
    a_op(2, 1'b0, 12'h010, 32'h0, 4'h0);

    @(posedge clk); #1;
    v = 3'b011; we = 3'b001; addr[11:0] = 12'd7; addr[23:12] = 12'd7; wdata[31:0] = 32'h1234; be[3:0] = 4'hF;
    @(negedge clk);
    chk("haz_grant0", 128'(rdy), 128'(3'b001));
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("haz_grant1", 128'(rdy), 128'(3'b010));
    @(posedge clk); #1;
    v[1] = 1'b0; we = '0;
    @(negedge clk);
    chk("haz_rdata", 128'(rd[63:32]), 128'(32'h1234));

    b_op(1'b1, 12'h010, 32'hDEADBEEF);
    b_op(1'b0, 12'h010, 32'h0);
    @(negedge clk);
    chk("b_lat_early", 128'(b_rv), 128'(0));
    @(negedge clk);
    chk("b_lat_valid", 128'(b_rv), 128'(1));
    chk("b_rdata", 128'(b_rd), 128'(32'hDEADBEEF));
`ifdef RAM_ARB_ERR_EN
    chk("b_err_quiet", 128'(b_err), 128'(0));
`endif

    for (int i = 100; i <= 130; i++) a_op(0, 1'b1, 12'(i), $urandom, 4'hF);
    a_op(2, 1'b0, 12'd100, 32'h0, 4'h0);
    nacc = '{0, 0, 0};
    foreach (tv[i]) begin
      @(posedge clk); #1;
      v = tv[i].v;
      for (int p = 0; p < 3; p++) addr[p*12 +: 12] = 12'(100 + p + 3 * nacc[p]);
      @(negedge clk);
      chk($sformatf("rr_row%0d", i), 128'(rdy), 128'(tv[i].rdy));
    end
    @(posedge clk); #1;
    v = '0;
    repeat (3) @(posedge clk);

    a_op(1, 1'b0, 12'd3000, 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_rdata", 128'(rd[63:32]), 128'(0));
    chk("oor_valid", 128'(rv), 128'(3'b010));
`ifdef RAM_ARB_ERR_EN
    chk("oor_err", 128'(err), 128'(3'b010));
`endif
    a_op(0, 1'b1, 12'd1095, 32'hCAFEF00D, 4'hF);
    a_op(2, 1'b1, 12'd4095, 32'h11111111, 4'hF);
    @(negedge clk);
    chk("oor_wr_no_rsp", 128'(rv), 128'(0));
`ifdef RAM_ARB_ERR_EN
    chk("oor_werr", 128'(err), 128'(3'b100));
`endif
    a_op(2, 1'b0, 12'd1095, 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_alias_intact", 128'(rd[95:64]), 128'(32'hCAFEF00D));

    @(posedge clk); #1;
    v = 3'b001; we = '0; addr[11:0] = 12'd100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", i), 128'(rdy), 128'(3'b001));
      @(posedge clk); #1;
      addr[11:0] = 12'(101 + i);
    end
    v = '0;
    repeat (3) @(posedge clk);

    b_op(1'b0, 12'h010, 32'h0);
    rst_n = 1'b0;
    sb.delete(); wq.delete();
    v = 3'b111; we = '0; addr = {12'd102, 12'd101, 12'd100};
    @(negedge clk);
    chk("midrst_ready", 128'(rdy), 128'(0));
    chk("midrst_valid", 128'(rv), 128'(0));
    chk("midrst_b_valid", 128'(b_rv), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_b_discard", 128'(b_rv), 128'(0));
    chk("rst_ptr0", 128'(rdy), 128'(3'b001));
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("rst_b_discard2", 128'(b_rv), 128'(0));
    chk("rst_next1", 128'(rdy), 128'(3'b010));
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(negedge clk);
    chk("rst_next2", 128'(rdy), 128'(3'b100));
    @(posedge clk); #1;
    v = '0;
    repeat (5) @(negedge clk);
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
